// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states
// and op-class decode helpers used by both the controller and datapath.
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU accumulate ops).
package mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // Divide class: selects the longer latency.
    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Multiply class; accumulate ops only count when the feature is built.
    function automatic logic is_mult_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_MADD) || (op == MD_MADDU);
`else
        return (op == MD_MULT) || (op == MD_MULTU);
`endif
    endfunction

    // Any op that occupies the unit for several cycles.
    function automatic logic is_multi_op(input logic [3:0] op);
        return is_div_op(op) || is_mult_op(op);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath for the multiply/divide unit. Produces the
// {HI,LO} value that the controller parks in its pending registers.
// Divide by zero, and any op without an arithmetic result, pass the
// current HI/LO through so the later commit leaves them unchanged.
// Optional feature macro: MDU_MADD_EN (adds the 64-bit accumulate path).
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;

    // Operands are widened explicitly so the 64-bit product is exact.
    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // SystemVerilog signed division truncates toward zero and the remainder
    // takes the dividend's sign, which is exactly the architectural behaviour.
    assign quot_s = $signed(a) / $signed(b);
    assign rem_s  = $signed(a) % $signed(b);
    assign quot_u = a / b;
    assign rem_u  = a % b;

`ifdef MDU_MADD_EN
    logic [63:0] acc_s;
    logic [63:0] acc_u;

    // Accumulate wraps modulo 2^64 simply by discarding the carry out.
    assign acc_s = {hi, lo} + prod_s;
    assign acc_u = {hi, lo} + prod_u;
`endif

    // Result select; default keeps the current HI/LO.
    always_comb begin
        res_hi = hi;
        res_lo = lo;
        case (op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV: begin
                if (b != 32'd0) begin
                    res_hi = rem_s;
                    res_lo = quot_s;
                end
            end
            MD_DIVU: begin
                if (b != 32'd0) begin
                    res_hi = rem_u;
                    res_lo = quot_u;
                end
            end
`ifdef MDU_MADD_EN
            MD_MADD:  {res_hi, res_lo} = acc_s;
            MD_MADDU: {res_hi, res_lo} = acc_u;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller. Owns HI/LO, models fixed multi-cycle
// latency with a down-counter, and requests a D-stage stall for MD-class
// instructions while a result is pending.
// Optional feature macro: MDU_MADD_EN (MADD/MADDU accumulate into HI/LO).
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [31:0]      hi_reg, hi_next;
    logic [31:0]      lo_reg, lo_next;
    logic [31:0]      p_hi_reg, p_hi_next;
    logic [31:0]      p_lo_reg, p_lo_next;
    logic [31:0]      arith_hi;
    logic [31:0]      arith_lo;
    logic             multi_op;

    assign multi_op = is_multi_op(md_op);

    mdu_arith u_arith (
        .op     (md_op),
        .a      (a),
        .b      (b),
        .hi     (hi_reg),
        .lo     (lo_reg),
        .res_hi (arith_hi),
        .res_lo (arith_lo)
    );

    // Next-state logic: issue in IDLE, count down and commit in BUSY.
    // Any start seen while BUSY is ignored.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        p_hi_next  = p_hi_reg;
        p_lo_next  = p_lo_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (multi_op) begin
                        p_hi_next  = arith_hi;
                        p_lo_next  = arith_lo;
                        cnt_next   = is_div_op(md_op) ? CNT_W'(DIV_CYCLES)
                                                      : CNT_W'(MULT_CYCLES);
                        state_next = ST_BUSY;
                    end else if (md_op == MD_MTHI) begin
                        hi_next = a;
                    end else if (md_op == MD_MTLO) begin
                        lo_next = a;
                    end
                end
            end
            ST_BUSY: begin
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    hi_next    = p_hi_reg;
                    lo_next    = p_lo_reg;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register; reset discards any pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            p_hi_reg  <= '0;
            p_lo_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            p_hi_reg  <= p_hi_next;
            p_lo_reg  <= p_lo_next;
        end
    end

    assign busy   = (state_reg == ST_BUSY);
    assign stall  = d_md & (busy | (start & multi_op));
    assign hi_out = hi_reg;
    assign lo_out = lo_reg;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: expected {HI,LO} values go into a queue at
// issue and are popped when the unit reports completion.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        d_md;
    logic        busy;
    logic        stall;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb[$];
    logic [31:0] cur_hi = 32'd0;
    logic [31:0] cur_lo = 32'd0;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .a      (a),
        .b      (b),
        .d_md   (d_md),
        .busy   (busy),
        .stall  (stall),
        .hi_out (hi_out),
        .lo_out (lo_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, follow it through n busy cycles, then compare the
    // committed HI/LO against the head of the scoreboard.
    task automatic do_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input int n, input string tag);
        logic [63:0] exp;
        chk({tag, " idle before issue"}, {31'd0, busy}, 32'd0);
        start = 1'b1;
        md_op = op;
        a     = av;
        b     = bv;
        #1;
        chk({tag, " stall issue"}, {31'd0, stall}, {31'd0, (d_md && (n > 0))});
        step();
        start = 1'b0;
        md_op = MD_NONE;
        a     = 32'd0;
        b     = 32'd0;
        for (int k = 1; k <= n; k++) begin
            chk($sformatf("%s busy c%0d", tag, k), {31'd0, busy}, 32'd1);
            chk($sformatf("%s hi held c%0d", tag, k), hi_out, cur_hi);
            chk($sformatf("%s lo held c%0d", tag, k), lo_out, cur_lo);
            chk($sformatf("%s stall c%0d", tag, k), {31'd0, stall}, {31'd0, d_md});
            step();
        end
        if (sb.size() == 0) begin
            chk({tag, " scoreboard empty"}, 32'd1, 32'd0);
            exp = {cur_hi, cur_lo};
        end else begin
            exp = sb.pop_front();
        end
        chk({tag, " busy done"}, {31'd0, busy}, 32'd0);
        chk({tag, " stall done"}, {31'd0, stall}, 32'd0);
        chk({tag, " hi"}, hi_out, exp[63:32]);
        chk({tag, " lo"}, lo_out, exp[31:0]);
        cur_hi = exp[63:32];
        cur_lo = exp[31:0];
        $display("txn %-10s op=%0d a=%h b=%h -> hi=%h lo=%h", tag, op, av, bv, hi_out, lo_out);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] re;

        reset = 1'b1;
        start = 1'b0;
        md_op = MD_NONE;
        a     = 32'd0;
        b     = 32'd0;
        d_md  = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("reset hi", hi_out, 32'd0);
        chk("reset lo", lo_out, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset stall", {31'd0, stall}, 32'd0);
        d_md = 1'b0;

        // Signed multiply of -3 by 5.
        sb.push_back({32'hFFFF_FFFF, 32'hFFFF_FFF1});
        do_op(MD_MULT, 32'hFFFF_FFFD, 32'd5, MC, "mult");

        // Signed divide -7 / 2: quotient -3, remainder -1.
        sb.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, DC, "div");

        sb.push_back({32'd1, 32'd3});
        do_op(MD_DIVU, 32'd7, 32'd2, DC, "divu");

        // MTHI with an MD-class instruction behind it: no stall at all.
        d_md = 1'b1;
        sb.push_back({32'h0000_1234, 32'd3});
        do_op(MD_MTHI, 32'h0000_1234, 32'd0, 0, "mthi");

        // MULTU 2^16 * 2^16 = 2^32, stall held while d_md is set.
        sb.push_back({32'd1, 32'd0});
        do_op(MD_MULTU, 32'h0001_0000, 32'h0001_0000, MC, "multu");
        d_md = 1'b0;

        // No-effect op codes.
        sb.push_back({32'd1, 32'd0});
        do_op(MD_NONE, 32'h1111_1111, 32'h2222_2222, 0, "none");
        sb.push_back({32'd1, 32'd0});
        do_op(4'hF, 32'h3333_3333, 32'h4444_4444, 0, "undef");
`ifndef MDU_MADD_EN
        sb.push_back({32'd1, 32'd0});
        do_op(MD_MADDU, 32'd1, 32'd1, 0, "maddu_off");
`endif

        // Divide by zero keeps HI/LO.
        sb.push_back({32'hAAAA_0000, 32'd0});
        do_op(MD_MTHI, 32'hAAAA_0000, 32'd0, 0, "mthi2");
        sb.push_back({32'hAAAA_0000, 32'h0000_5555});
        do_op(MD_MTLO, 32'h0000_5555, 32'd0, 0, "mtlo2");
        sb.push_back({32'hAAAA_0000, 32'h0000_5555});
        do_op(MD_DIV, 32'd100, 32'd0, DC, "div0");

        // A few random unsigned ops.
        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            re = {32'd0, ra} * {32'd0, rb};
            sb.push_back(re);
            do_op(MD_MULTU, ra, rb, MC, $sformatf("rmultu%0d", i));
            ra = $urandom;
            rb = $urandom_range(1, 5000);
            sb.push_back({ra % rb, ra / rb});
            do_op(MD_DIVU, ra, rb, DC, $sformatf("rdivu%0d", i));
        end

`ifdef MDU_MADD_EN
        sb.push_back({32'd0, 32'd0});
        do_op(MD_MTHI, 32'd0, 32'd0, 0, "mthi3");
        sb.push_back({32'd0, 32'hFFFF_FFFF});
        do_op(MD_MTLO, 32'hFFFF_FFFF, 32'd0, 0, "mtlo3");
        sb.push_back({32'd1, 32'd0});
        do_op(MD_MADDU, 32'd1, 32'd1, MC, "maddu");
        // {1,0} + (-1 * 1) = {0, FFFFFFFF}
        sb.push_back({32'd0, 32'hFFFF_FFFF});
        do_op(MD_MADD, 32'hFFFF_FFFF, 32'd1, MC, "madd");
`endif

        // Reset during busy cycle 3 of a DIVU discards the result.
        chk("rst idle before issue", {31'd0, busy}, 32'd0);
        start = 1'b1;
        md_op = MD_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        step();
        start = 1'b0;
        md_op = MD_NONE;
        chk("rst busy c1", {31'd0, busy}, 32'd1);
        step();
        chk("rst busy c2", {31'd0, busy}, 32'd1);
        step();
        chk("rst busy c3", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst busy after", {31'd0, busy}, 32'd0);
        chk("rst hi after", hi_out, 32'd0);
        chk("rst lo after", lo_out, 32'd0);
        repeat (DC + 2) step();
        chk("rst no late commit hi", hi_out, 32'd0);
        chk("rst no late commit lo", lo_out, 32'd0);
        chk("rst stays idle", {31'd0, busy}, 32'd0);
        $display("txn reset_mid  op=%0d a=%h b=%h -> hi=%h lo=%h", MD_DIVU, 32'd100, 32'd7, hi_out, lo_out);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
